// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard scoreboard for the decode stage.
// Tracks in-flight register writers over DEPTH stages and selects the youngest producer per source.
module fwd_scoreboard #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NSRC       = 2,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_STAGE = 2,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     pipe_en,
   input  logic                     flush,
   input  logic                     cnt_clr,
   input  logic                     id_valid,
   input  logic                     id_regwr,
   input  logic                     id_load,
   input  logic [REG_AW-1:0]        id_rd,
   input  logic [NSRC*REG_AW-1:0]   id_src,
   input  logic [NSRC-1:0]          id_src_used,
   input  logic [NSRC*DATA_W-1:0]   rf_data,
   input  logic [DEPTH*DATA_W-1:0]  stage_data,
   output logic [NSRC*DATA_W-1:0]   opnd_data,
   output logic [NSRC*SEL_W-1:0]    fwd_sel,
   output logic                     stall,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [SEL_W-1:0]         inflight
);

   logic [DEPTH:1]             ent_valid;
   logic [DEPTH:1]             ent_load;
   logic [DEPTH:1][REG_AW-1:0] ent_rd;
   logic [NSRC-1:0]            hazard;
   logic                       alloc;

   // Per-source priority chain: walk from the oldest stage towards stage 1 so the youngest match wins.
   for (genvar i = 0; i < NSRC; i++) begin : gen_src
      logic [REG_AW-1:0] src;
      logic [SEL_W-1:0]  pick [1:DEPTH+1];
      logic              hz   [1:DEPTH+1];
      logic [DATA_W-1:0] val  [1:DEPTH+1];

      assign src          = id_src[i*REG_AW +: REG_AW];
      assign pick[DEPTH+1] = '0;
      assign hz[DEPTH+1]   = 1'b0;
      assign val[DEPTH+1]  = rf_data[i*DATA_W +: DATA_W];

      for (genvar k = 1; k <= DEPTH; k++) begin : gen_stage
         localparam bit EARLY = (k < LOAD_STAGE);
         logic m;
         assign m       = id_src_used[i] && ent_valid[k] && (ent_rd[k] == src) && (src != '0);
         assign pick[k] = m ? SEL_W'(k) : pick[k+1];
         assign hz[k]   = m ? (ent_load[k] && EARLY) : hz[k+1];
         assign val[k]  = m ? stage_data[(k-1)*DATA_W +: DATA_W] : val[k+1];
      end

      // A hazarded source falls back to the register file; its value is ignored while stalled.
      assign hazard[i]                    = hz[1];
      assign fwd_sel[i*SEL_W +: SEL_W]    = hz[1] ? '0 : pick[1];
      assign opnd_data[i*DATA_W +: DATA_W] = hz[1] ? rf_data[i*DATA_W +: DATA_W] : val[1];
   end

   assign stall    = id_valid && (|hazard) && !flush;
   assign alloc    = id_valid && id_regwr && (id_rd != '0) && !stall && !flush;
   assign inflight = SEL_W'($countones(ent_valid));

   // Writer pipeline: stage 1 receives decode (or a bubble), the last stage retires.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ent_valid <= '0;
         ent_load  <= '0;
         ent_rd    <= '0;
      end else if (pipe_en) begin
         ent_valid <= {ent_valid[DEPTH-1:1], alloc};
         ent_load  <= {ent_load[DEPTH-1:1], id_load};
         ent_rd    <= {ent_rd[DEPTH-1:1], id_rd};
      end
   end

   // Lost issue slots; clear wins, saturates at all-ones.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (stall && pipe_en && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against a list-based model of in-flight writers.
module tb_fwd_scoreboard;
   localparam int unsigned REG_AW = 5, DATA_W = 32, NSRC = 2, DEPTH = 3, LOAD_STAGE = 2;
   localparam int unsigned CNT_W = 16, SEL_W = 2;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic pipe_en, flush, cnt_clr, id_valid, id_regwr, id_load;
   logic [REG_AW-1:0]       id_rd;
   logic [NSRC*REG_AW-1:0]  id_src;
   logic [NSRC-1:0]         id_src_used;
   logic [NSRC*DATA_W-1:0]  rf_data;
   logic [DEPTH*DATA_W-1:0] stage_data;
   logic [NSRC*DATA_W-1:0]  opnd_data, opnd_data2;
   logic [NSRC*SEL_W-1:0]   fwd_sel, fwd_sel2;
   logic                    stall, stall2;
   logic [CNT_W-1:0]        stall_cnt;
   logic [1:0]              stall_cnt2;
   logic [SEL_W-1:0]        inflight, inflight2;

   fwd_scoreboard #(.REG_AW(REG_AW), .DATA_W(DATA_W), .NSRC(NSRC), .DEPTH(DEPTH),
                    .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .flush(flush), .cnt_clr(cnt_clr),
      .id_valid(id_valid), .id_regwr(id_regwr), .id_load(id_load), .id_rd(id_rd),
      .id_src(id_src), .id_src_used(id_src_used), .rf_data(rf_data), .stage_data(stage_data),
      .opnd_data(opnd_data), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt),
      .inflight(inflight));

   fwd_scoreboard #(.REG_AW(REG_AW), .DATA_W(DATA_W), .NSRC(NSRC), .DEPTH(DEPTH),
                    .LOAD_STAGE(LOAD_STAGE), .CNT_W(2)) dut2 (
      .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .flush(flush), .cnt_clr(cnt_clr),
      .id_valid(id_valid), .id_regwr(id_regwr), .id_load(id_load), .id_rd(id_rd),
      .id_src(id_src), .id_src_used(id_src_used), .rf_data(rf_data), .stage_data(stage_data),
      .opnd_data(opnd_data2), .fwd_sel(fwd_sel2), .stall(stall2), .stall_cnt(stall_cnt2),
      .inflight(inflight2));

   always #5 CLK = ~CLK;

   // Model: list of in-flight writers indexed by stage, plus the two counters.
   bit   mv  [1:DEPTH];
   int   mrd [1:DEPTH];
   bit   mld [1:DEPTH];
   int   mcnt, mcnt2;
   bit   exp_stall;
   int   exp_sel  [NSRC];
   logic [DATA_W-1:0] exp_data [NSRC];
   int   exp_infl;
   int   checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 1; k <= DEPTH; k++) begin
         mv[k] = 0; mrd[k] = 0; mld[k] = 0;
      end
      mcnt = 0; mcnt2 = 0;
   endfunction

   function automatic void model_eval();
      bit any;
      any = 0;
      for (int i = 0; i < NSRC; i++) begin
         int src;
         bit found;
         src = int'(id_src[i*REG_AW +: REG_AW]);
         found = 0;
         exp_sel[i]  = 0;
         exp_data[i] = rf_data[i*DATA_W +: DATA_W];
         for (int k = 1; k <= DEPTH; k++) begin
            if (!found && id_src_used[i] && mv[k] && mrd[k] == src && src != 0) begin
               found = 1;
               if (mld[k] && k < LOAD_STAGE) any = 1;
               else begin
                  exp_sel[i]  = k;
                  exp_data[i] = stage_data[(k-1)*DATA_W +: DATA_W];
               end
            end
         end
      end
      exp_stall = id_valid && any && !flush;
      exp_infl = 0;
      for (int k = 1; k <= DEPTH; k++) if (mv[k]) exp_infl++;
   endfunction

   function automatic void model_step();
      if (pipe_en) begin
         for (int k = DEPTH; k > 1; k--) begin
            mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mld[k] = mld[k-1];
         end
         mv[1]  = id_valid && id_regwr && (id_rd != 0) && !exp_stall && !flush;
         mrd[1] = int'(id_rd);
         mld[1] = id_load;
      end
      if (cnt_clr) begin
         mcnt = 0; mcnt2 = 0;
      end else if (exp_stall && pipe_en) begin
         if (mcnt < 65535) mcnt++;
         if (mcnt2 < 3) mcnt2++;
      end
   endfunction

   task automatic settle();
      #3;
      model_eval();
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("stall_w2", 64'(stall2), 64'(exp_stall));
      chk("inflight", 64'(inflight), 64'(exp_infl));
      chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
      chk("stall_cnt_w2", 64'(stall_cnt2), 64'(mcnt2));
      for (int i = 0; i < NSRC; i++) begin
         chk($sformatf("fwd_sel%0d", i), 64'(fwd_sel[i*SEL_W +: SEL_W]), 64'(exp_sel[i]));
         chk($sformatf("opnd_data%0d", i), 64'(opnd_data[i*DATA_W +: DATA_W]), 64'(exp_data[i]));
      end
   endtask

   task automatic advance();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic set_id(input bit v, input bit w, input bit ld, input int rd,
                         input int s0, input int s1, input bit [1:0] used);
      id_valid = v; id_regwr = w; id_load = ld; id_rd = 5'(rd);
      id_src = {5'(s1), 5'(s0)}; id_src_used = used;
      pipe_en = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
   endtask

   // Asynchronous reset asserted and released between clock edges.
   task automatic mid_reset();
      #1 nRST = 1'b0;
      #1;
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_stall_cnt_w2", 64'(stall_cnt2), 64'd0);
      chk("rst_fwd_sel", 64'(fwd_sel), 64'd0);
      chk("rst_opnd", 64'(opnd_data), 64'(rf_data));
      model_reset();
      @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   initial begin
      model_reset();
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      pipe_en = 1'b0;
      rf_data = '0;
      stage_data = '0;
      settle();
      chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("reset_inflight", 64'(inflight), 64'd0);
      #4 nRST = 1'b1;
      @(posedge CLK);
      #1;

      // ALU back-to-back
      set_id(1, 1, 0, 5, 0, 0, 2'b00);
      settle(); advance();
      set_id(1, 0, 0, 0, 5, 0, 2'b01);
      stage_data = {32'h0, 32'h0, 32'h1234};
      settle();
      chk("alu_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd1);
      chk("alu_opnd0", 64'(opnd_data[0 +: DATA_W]), 64'h1234);
      chk("alu_stall", 64'(stall), 64'd0);
      advance();

      // Load-use: one stall, then forward from stage 2
      set_id(1, 1, 1, 8, 0, 0, 2'b00);
      settle(); advance();
      set_id(1, 0, 0, 0, 0, 8, 2'b10);
      settle();
      chk("lu_stall", 64'(stall), 64'd1);
      advance();
      stage_data = {32'h3333, 32'hCAFE, 32'h1111};
      settle();
      chk("lu_cnt", 64'(stall_cnt), 64'd1);
      chk("lu_stall2", 64'(stall), 64'd0);
      chk("lu_sel1", 64'(fwd_sel[SEL_W +: SEL_W]), 64'd2);
      chk("lu_opnd1", 64'(opnd_data[DATA_W +: DATA_W]), 64'hCAFE);
      advance();

      // Priority and retirement
      set_id(1, 1, 0, 3, 0, 0, 2'b00); settle(); advance();
      set_id(0, 0, 0, 0, 0, 0, 2'b00); settle(); advance();
      set_id(1, 1, 0, 3, 0, 0, 2'b00); settle(); advance();
      set_id(1, 0, 0, 0, 3, 0, 2'b01);
      rf_data = {32'hBBBB0001, 32'hAAAA0000};
      stage_data = {32'h33333333, 32'h22222222, 32'h11111111};
      settle();
      chk("prio_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd1);
      advance(); settle();
      chk("mid_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd2);
      advance(); settle();
      chk("wb_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd3);
      chk("wb_opnd0", 64'(opnd_data[0 +: DATA_W]), 64'h33333333);
      advance(); settle();
      chk("ret_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
      chk("ret_opnd0", 64'(opnd_data[0 +: DATA_W]), 64'hAAAA0000);
      advance();

      // r0 never tracked; unused source never matches
      set_id(1, 1, 0, 0, 0, 0, 2'b00); settle(); advance();
      set_id(0, 0, 0, 0, 0, 0, 2'b00); settle();
      chk("r0_inflight", 64'(inflight), 64'd0);
      set_id(1, 1, 1, 7, 0, 0, 2'b00); settle(); advance();
      set_id(1, 0, 0, 0, 0, 7, 2'b01); settle();
      chk("r0_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
      chk("unused_sel1", 64'(fwd_sel[SEL_W +: SEL_W]), 64'd0);
      chk("unused_stall", 64'(stall), 64'd0);
      chk("r7_inflight", 64'(inflight), 64'd1);
      advance();

      // Freeze with hazard, then flush while hazarded
      set_id(1, 1, 1, 9, 0, 0, 2'b00); settle(); advance();
      for (int n = 0; n < 4; n++) begin
         set_id(1, 0, 0, 0, 9, 0, 2'b01);
         pipe_en = 1'b0;
         settle();
         chk("frz_stall", 64'(stall), 64'd1);
         chk("frz_cnt", 64'(stall_cnt), 64'd1);
         chk("frz_inflight", 64'(inflight), 64'd2);
         advance();
      end
      set_id(1, 1, 0, 10, 9, 0, 2'b01);
      flush = 1'b1;
      settle();
      chk("flush_stall", 64'(stall), 64'd0);
      advance();
      set_id(1, 0, 0, 0, 10, 0, 2'b01); settle();
      chk("flush_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
      chk("flush_inflight", 64'(inflight), 64'd1);
      advance();

      // Clear wins over a stall
      set_id(1, 1, 1, 11, 0, 0, 2'b00); settle(); advance();
      set_id(1, 0, 0, 0, 11, 0, 2'b01);
      cnt_clr = 1'b1;
      settle();
      chk("clr_stall", 64'(stall), 64'd1);
      advance();
      set_id(0, 0, 0, 0, 0, 0, 2'b00); settle();
      chk("clr_cnt", 64'(stall_cnt), 64'd0);
      chk("clr_cnt_w2", 64'(stall_cnt2), 64'd0);
      advance();

      // Five stall slots: 16-bit counter reaches 5, 2-bit counter saturates at 3
      for (int n = 0; n < 5; n++) begin
         set_id(1, 1, 1, 12, 0, 0, 2'b00); settle(); advance();
         set_id(1, 0, 0, 0, 0, 12, 2'b10); settle(); advance();
      end
      set_id(0, 0, 0, 0, 0, 0, 2'b00); settle();
      chk("sat_cnt", 64'(stall_cnt), 64'd5);
      chk("sat_cnt_w2", 64'(stall_cnt2), 64'd3);
      advance();

      // Randomized traffic with a mid-stream asynchronous reset
      for (int n = 0; n < 2000; n++) begin
         if (n == 1000) mid_reset();
         id_valid    = ($urandom_range(0, 3) != 0);
         id_regwr    = $urandom_range(0, 1) != 0;
         id_load     = ($urandom_range(0, 2) == 0);
         id_rd       = 5'($urandom_range(0, 7));
         id_src      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         id_src_used = 2'($urandom_range(0, 3));
         pipe_en     = ($urandom_range(0, 7) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         cnt_clr     = ($urandom_range(0, 63) == 0);
         rf_data     = {$urandom, $urandom};
         stage_data  = {$urandom, $urandom, $urandom};
         settle();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and hazard scoreboard for the decode stage of the pipelined core. It tracks every in-flight register writer across `DEPTH` post-decode stages, selects the youngest producer for each of `NSRC` source operands, and muxes the forwarded value. It raises a load-use stall when the producer's data is not yet available, and counts lost issue slots. It supersedes fixed two-operand, fixed-stage forwarding logic.

## Interface

Parameters:

- `REG_AW`, 5, register address width.
- `DATA_W`, 32, data width.
- `NSRC`, 2, number of source operands per decoded instruction.
- `DEPTH`, 3, tracked stages after decode (1 = EX, …, `DEPTH` = WB); must be ≥ 2.
- `LOAD_STAGE`, 2, first stage at which load data is valid; must satisfy 1 ≤ `LOAD_STAGE` ≤ `DEPTH`.
- `CNT_W`, 16, stall counter width.
- Derived: `SEL_W` = clog2(`DEPTH`+1).

Ports:

- `CLK`  in  1  clock; one clock domain; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `pipe_en`  in  1  pipeline advances this cycle.
- `flush`  in  1  kill the instruction currently in decode.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_regwr`  in  1  decode instruction writes a register.
- `id_load`  in  1  decode instruction is a load.
- `id_rd`  in  `REG_AW`  destination register.
- `id_src`  in  `NSRC`*`REG_AW`  source i at [i*`REG_AW` +: `REG_AW`].
- `id_src_used`  in  `NSRC`  source i is actually read.
- `rf_data`  in  `NSRC`*`DATA_W`  register-file read data per source.
- `stage_data`  in  `DEPTH`*`DATA_W`  result at stage k in slot [(k-1)*`DATA_W` +: `DATA_W`]; for loads at k ≥ `LOAD_STAGE` this is the memory data.
- `opnd_data`  out  `NSRC`*`DATA_W`  resolved operand values.
- `fwd_sel`  out  `NSRC`*`SEL_W`  0 = register file, k = stage k.
- `stall`  out  1  hold decode and insert a bubble.
- `stall_cnt`  out  `CNT_W`  count of lost issue slots.
- `inflight`  out  `SEL_W`  number of valid entries.

## Operation

- State: entry[k] for k = 1..`DEPTH`, each holding {valid, rd, load}. Plus `stall_cnt`.
- Match for source i at stage k: `id_src_used`[i] AND entry[k].valid AND entry[k].rd == src AND src != 0. The lowest k (youngest producer) wins.
- For the winning stage k:
  - If entry[k].load and k < `LOAD_STAGE`, source i is hazarded. `fwd_sel` = 0 and `opnd_data` = `rf_data`; the value is don't-care while stalled.
  - Otherwise `fwd_sel` = k and `opnd_data` = `stage_data`[k].
- No match: `fwd_sel` = 0, `opnd_data` = `rf_data`[i].
- `stall` = `id_valid` AND (any source hazarded) AND NOT `flush`. Multiple hazarded sources produce a single stall.
- Update when `pipe_en` = 1:
  - Entry[k+1] ← entry[k]; entry[`DEPTH`] is retired.
  - Entry[1].valid ← `id_valid` AND `id_regwr` AND (`id_rd` != 0) AND NOT `stall` AND NOT `flush`, with rd and load taken from decode. A stall or flush therefore inserts a bubble.
- When `pipe_en` = 0: all entries hold; outputs keep being evaluated.
- `stall_cnt`:
  - `cnt_clr` has priority and clears the counter to 0.
  - Otherwise it increments when `stall` AND `pipe_en`.
  - It saturates at all-ones with no wrap.
- `inflight` = popcount of entry valid bits.
- Register 0 is never tracked and never forwarded.

## Timing

- `opnd_data`, `fwd_sel`, `stall` and `inflight` are combinational from the current entries and current inputs. There is no added latency.
- Entries and `stall_cnt` update on the `CLK` rising edge.
- Asserting `nRST` low immediately clears all entries and `stall_cnt`, whether or not a clock edge occurs. While in reset:
  - `stall` = 0, `inflight` = 0, `stall_cnt` = 0.
  - `fwd_sel` = 0 and `opnd_data` = `rf_data`.
- Load-use with `LOAD_STAGE` = 2:
  - Exactly one stall cycle, provided `pipe_en` is held at 1.
  - In the following cycle the load is in stage 2 and `fwd_sel` = 2.
- A producer in stage `DEPTH` (WB) is still forwarded, because the register file is not write-through.
- Once a producer retires past stage `DEPTH`, the operand comes from `rf_data`.
- `flush` together with a hazard: `stall` = 0 and entry[1] is loaded invalid.
- With `pipe_en` = 0 and a hazard present: `stall` = 1, `stall_cnt` is unchanged, and the entries are unchanged.

## Test plan

- ALU back-to-back: issue rd=5 (non-load), then decode src0=5 with `stage_data`[1]=0x1234 → `fwd_sel`0=1, `opnd_data`0=0x1234, `stall`=0.
- Load-use: issue load rd=8, then decode src1=8:
  - Cycle 1: `stall`=1; entry[1] becomes a bubble; `stall_cnt`=1.
  - Cycle 2: `fwd_sel`1=2, `opnd_data`1=`stage_data`[2]=0xCAFE, `stall`=0.
- Priority and retirement: r3 valid in stages 1 and 3 → `fwd_sel`=1. After 3 advances with no new writer of r3 → `fwd_sel`=0 and `opnd_data`=`rf_data`.
- r0 and unused sources: writer rd=0 → `inflight` does not increase; src=0 → `fwd_sel`=0. Matching src with `id_src_used`=0 → `fwd_sel`=0, no stall.
- Freeze and flush:
  - Hazard with `pipe_en`=0 for 4 cycles → `stall`=1 throughout, `stall_cnt` and `inflight` unchanged.
  - `flush`=1 while hazarded → `stall`=0 and no entry is allocated.
- Counter and reset:
  - `CNT_W`=2 with 5 stall slots → `stall_cnt`=3 (saturated).
  - `cnt_clr` together with a stall → `stall_cnt`=0.
  - `nRST` pulsed low mid-stream, between clock edges → `inflight`=0, `stall`=0, `stall_cnt`=0 immediately.
